// File: rtl/ryu_motion_ctrl_if.sv
// Button/vsync inputs and sprite position/pose outputs of the Ryu motion controller.
// The master side (player input decoder) drives buttons and vsync; the slave side is the controller.
interface ryu_motion_ctrl_if;
  logic       vs;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_punch;
  logic [9:0] RyuX;
  logic [9:0] RyuY;
  logic [2:0] sprite;
  logic       frame_tick;

  modport master (
    output vs, btn_left, btn_right, btn_up, btn_down, btn_punch,
    input  RyuX, RyuY, sprite, frame_tick
  );

  modport slave (
    input  vs, btn_left, btn_right, btn_up, btn_down, btn_punch,
    output RyuX, RyuY, sprite, frame_tick
  );
endinterface

// File: rtl/ryu_motion_ctrl.sv
// Per-frame movement FSM for Ryu: walk, crouch, timed punch and ballistic jump.
// Everything advances once per vsync rising edge; outputs are held between frames.
module ryu_motion_ctrl #(
  parameter int X_INIT       = 100,
  parameter int Y_GROUND     = 300,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 560,
  parameter int WALK_STEP    = 2,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1,
  parameter int PUNCH_FRAMES = 12
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  ryu_motion_ctrl_if.slave bus
);

  // State encoding doubles as the sprite code seen by the sprite mux.
  localparam logic [2:0] ST_STAND  = 3'd0;
  localparam logic [2:0] ST_PUNCH  = 3'd1;
  localparam logic [2:0] ST_JUMP   = 3'd2;
  localparam logic [2:0] ST_CROUCH = 3'd3;
  localparam logic [2:0] ST_WALK_L = 3'd4;
  localparam logic [2:0] ST_WALK_R = 3'd5;

  localparam logic [9:0]        X_INIT_U   = 10'(X_INIT);
  localparam logic [9:0]        Y_GROUND_U = 10'(Y_GROUND);
  localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
  localparam logic signed [10:0] Y_GROUND_S = 11'(Y_GROUND);
  localparam logic signed [10:0] STEP_S     = 11'(WALK_STEP);
  localparam logic signed [3:0]  STEP_DX    = 4'(WALK_STEP);
  localparam logic signed [6:0]  JUMP_VY    = 7'(-JUMP_V0);
  localparam logic signed [6:0]  GRAVITY_VY = 7'(GRAVITY);
  localparam logic [3:0]         PUNCH_LAST = 4'(PUNCH_FRAMES - 1);

  function automatic logic [9:0] clamp_x(input logic signed [10:0] v);
    logic [9:0] r;
    if (v < X_MIN_S) begin
      r = X_MIN_S[9:0];
    end else if (v > X_MAX_S) begin
      r = X_MAX_S[9:0];
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

  logic                vs_q_r;
  logic                tick_r;
  logic                punch_q_r;
  logic [2:0]          state_r;
  logic [9:0]          x_r;
  logic [9:0]          y_r;
  logic signed [6:0]   vy_r;
  logic signed [3:0]   dx_r;
  logic [3:0]          cnt_r;

  logic [2:0]          state_s;
  logic [9:0]          x_s;
  logic [9:0]          y_s;
  logic signed [6:0]   vy_s;
  logic signed [3:0]   dx_s;
  logic [3:0]          cnt_s;

  logic signed [10:0]  x_ext_s;
  logic signed [10:0]  y_ext_s;
  logic signed [10:0]  vy_ext_s;
  logic signed [10:0]  dx_ext_s;
  logic signed [10:0]  y_fall_s;
  logic                left_only_s;
  logic                right_only_s;
  logic                press_s;

  assign x_ext_s      = {1'b0, x_r};
  assign y_ext_s      = {1'b0, y_r};
  assign vy_ext_s     = {{4{vy_r[6]}}, vy_r};
  assign dx_ext_s     = {{7{dx_r[3]}}, dx_r};
  assign y_fall_s     = y_ext_s + vy_ext_s;
  assign left_only_s  = bus.btn_left & ~bus.btn_right;
  assign right_only_s = bus.btn_right & ~bus.btn_left;
  assign press_s      = bus.btn_punch & ~punch_q_r;

  // Next-state and next-position computation, applied only on a frame tick.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    vy_s    = vy_r;
    dx_s    = dx_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_PUNCH: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_STAND;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_JUMP: begin
        x_s = clamp_x(x_ext_s + dx_ext_s);
        // Only a falling (or apex) body can land; rising frames never snap to ground.
        if (!vy_r[6] && (y_fall_s >= Y_GROUND_S)) begin
          y_s     = Y_GROUND_U;
          vy_s    = 7'sd0;
          state_s = ST_STAND;
        end else begin
          y_s  = y_fall_s[9:0];
          vy_s = vy_r + GRAVITY_VY;
        end
      end
      ST_STAND, ST_CROUCH, ST_WALK_L, ST_WALK_R: begin
        if (press_s) begin
          state_s = ST_PUNCH;
          cnt_s   = PUNCH_LAST;
        end else if (bus.btn_up) begin
          state_s = ST_JUMP;
          vy_s    = JUMP_VY;
          if (left_only_s) begin
            dx_s = -STEP_DX;
          end else if (right_only_s) begin
            dx_s = STEP_DX;
          end else begin
            dx_s = 4'sd0;
          end
        end else if (bus.btn_down) begin
          state_s = ST_CROUCH;
        end else if (left_only_s) begin
          state_s = ST_WALK_L;
          x_s     = clamp_x(x_ext_s - STEP_S);
        end else if (right_only_s) begin
          state_s = ST_WALK_R;
          x_s     = clamp_x(x_ext_s + STEP_S);
        end else begin
          state_s = ST_STAND;
        end
      end
      default: begin
        state_s = ST_STAND;
      end
    endcase
  end

  // Vsync edge detection plus the per-frame state/position registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q_r    <= 1'b0;
      tick_r    <= 1'b0;
      punch_q_r <= 1'b0;
      state_r   <= ST_STAND;
      x_r       <= X_INIT_U;
      y_r       <= Y_GROUND_U;
      vy_r      <= 7'sd0;
      dx_r      <= 4'sd0;
      cnt_r     <= 4'd0;
    end else begin
      vs_q_r <= bus.vs;
      tick_r <= bus.vs & ~vs_q_r;
      if (tick_r) begin
        punch_q_r <= bus.btn_punch;
        state_r   <= state_s;
        x_r       <= x_s;
        y_r       <= y_s;
        vy_r      <= vy_s;
        dx_r      <= dx_s;
        cnt_r     <= cnt_s;
      end else begin
        punch_q_r <= punch_q_r;
        state_r   <= state_r;
        x_r       <= x_r;
        y_r       <= y_r;
        vy_r      <= vy_r;
        dx_r      <= dx_r;
        cnt_r     <= cnt_r;
      end
    end
  end

  assign bus.RyuX       = x_r;
  assign bus.RyuY       = y_r;
  assign bus.sprite     = state_r;
  assign bus.frame_tick = tick_r;

endmodule

// File: tb/tb_ryu_motion_ctrl.sv
// Scoreboard bench for ryu_motion_ctrl: stimulus pushes expected poses from a
// behavioural model, a monitor pops and compares on every frame_tick.
`timescale 1ns/1ps
module tb_ryu_motion_ctrl;

  logic vga_clk = 1'b0;
  logic reset_n;
  always #5 vga_clk = ~vga_clk;

  ryu_motion_ctrl_if bus();

  ryu_motion_ctrl dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] s;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: pose codes 0 stand,1 punch,2 jump,3 crouch,4 left,5 right.
  int m_pose, m_x, m_y, m_vy, m_dx, m_cnt;
  bit m_pq;

  function automatic int clampx(int v);
    if (v < 0) return 0;
    if (v > 560) return 560;
    return v;
  endfunction

  task automatic model_reset();
    m_pose = 0; m_x = 100; m_y = 300; m_vy = 0; m_dx = 0; m_cnt = 0; m_pq = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.x = m_x[9:0];
    e.y = m_y[9:0];
    e.s = m_pose[2:0];
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t e;
    e.x = bus.RyuX;
    e.y = bus.RyuY;
    e.s = bus.sprite;
    return e;
  endfunction

  task automatic model_tick(bit l, bit r, bit u, bit d, bit p);
    int ny;
    if (m_pose == 1) begin
      if (m_cnt == 0) m_pose = 0;
      else m_cnt = m_cnt - 1;
    end else if (m_pose == 2) begin
      m_x = clampx(m_x + m_dx);
      ny = m_y + m_vy;
      if (m_vy >= 0 && ny >= 300) begin
        m_y = 300; m_vy = 0; m_pose = 0;
      end else begin
        m_y = ny; m_vy = m_vy + 1;
      end
    end else begin
      if (p && !m_pq) begin
        m_pose = 1; m_cnt = 11;
      end else if (u) begin
        m_pose = 2; m_vy = -12;
        m_dx = (l && !r) ? -2 : ((r && !l) ? 2 : 0);
      end else if (d) begin
        m_pose = 3;
      end else if (l && !r) begin
        m_pose = 4; m_x = clampx(m_x - 2);
      end else if (r && !l) begin
        m_pose = 5; m_x = clampx(m_x + 2);
      end else begin
        m_pose = 0;
      end
    end
    m_pq = p;
  endtask

  task automatic chk3(string name, exp_t act, exp_t req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual x=%0d y=%0d s=%0d required x=%0d y=%0d s=%0d",
               name, act.x, act.y, act.s, req.x, req.y, req.s);
    end
  endtask

  task automatic check_now(string name, int x, int y, int s);
    exp_t e;
    e.x = x[9:0];
    e.y = y[9:0];
    e.s = s[2:0];
    chk3(name, dut_out(), e);
  endtask

  // One video frame: set buttons, pulse vs, let the frame settle.
  task automatic frame(bit l, bit r, bit u, bit d, bit p);
    @(negedge vga_clk);
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.btn_up    = u;
    bus.btn_down  = d;
    bus.btn_punch = p;
    model_tick(l, r, u, d, p);
    exp_q.push_back(model_out());
    bus.vs = 1'b1;
    repeat (3) @(negedge vga_clk);
    bus.vs = 1'b0;
    repeat (4) @(negedge vga_clk);
  endtask

  // Monitor: on each frame_tick, outputs must still hold the last pose, then take the new one.
  initial begin
    exp_t e;
    forever begin
      @(negedge vga_clk);
      if (bus.frame_tick === 1'b1) begin
        chk3("hold", dut_out(), last_exp);
        @(negedge vga_clk);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_tick actual=tick required=no_tick");
        end else begin
          e = exp_q.pop_front();
          chk3("tick", dut_out(), e);
          last_exp = e;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit l, r, u, d, p;
    bus.vs = 1'b0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_up = 1'b0;
    bus.btn_down = 1'b0; bus.btn_punch = 1'b0;
    reset_n = 1'b0;
    model_reset();
    last_exp = model_out();
    repeat (3) @(negedge vga_clk);
    check_now("reset", 100, 300, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge vga_clk);

    repeat (3) frame(0, 0, 0, 0, 0);
    check_now("idle", 100, 300, 0);
    repeat (5) frame(0, 1, 0, 0, 0);
    check_now("walk_right", 110, 300, 5);
    frame(1, 1, 0, 0, 0);
    check_now("left_and_right", 110, 300, 0);

    frame(0, 0, 1, 0, 0);
    check_now("takeoff", 110, 300, 2);
    repeat (12) frame(0, 0, 0, 0, 0);
    check_now("rise12", 110, 222, 2);
    frame(0, 0, 0, 0, 0);
    check_now("apex", 110, 222, 2);
    repeat (11) frame(0, 0, 0, 0, 0);
    check_now("descent24", 110, 288, 2);
    frame(0, 0, 0, 0, 0);
    check_now("land", 110, 300, 0);

    repeat (12) frame(0, 0, 0, 0, 1);
    check_now("punch12", 110, 300, 1);
    repeat (18) frame(0, 0, 0, 0, 1);
    check_now("punch_held", 110, 300, 0);
    frame(0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 1);
    repeat (11) frame(0, 0, 0, 0, 0);
    check_now("repunch12", 110, 300, 1);
    frame(0, 0, 0, 0, 0);
    check_now("repunch_done", 110, 300, 0);

    repeat (53) frame(1, 0, 0, 0, 0);
    check_now("left_x4", 4, 300, 4);
    repeat (3) frame(1, 0, 0, 0, 0);
    check_now("left_wall", 0, 300, 4);

    repeat (279) frame(0, 1, 0, 0, 0);
    check_now("right_558", 558, 300, 5);
    frame(0, 1, 1, 0, 0);
    check_now("jump_takeoff_558", 558, 300, 2);
    frame(0, 1, 0, 0, 0);
    check_now("jump_clamp", 560, 288, 2);
    repeat (24) frame(0, 1, 0, 0, 0);
    check_now("jump_clamp_land", 560, 300, 0);

    frame(0, 0, 1, 0, 0);
    repeat (5) frame(0, 0, 0, 0, 0);
    check_now("pre_reset", 560, 250, 2);
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    #1 check_now("async_reset", 100, 300, 0);
    model_reset();
    last_exp = model_out();
    @(negedge vga_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge vga_clk);
    frame(0, 0, 0, 0, 0);
    check_now("post_reset", 100, 300, 0);

    for (int i = 0; i < 300; i++) begin
      l = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      u = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 7) == 0);
      frame(l, r, u, d, p);
    end

    repeat (10) @(negedge vga_clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0 pending", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
